// File: rtl/mem_store_wbuf.sv
// Store write buffer: steers SB/SH/SW into word lanes, queues them and drains one RAM write per cycle.
// Optional load-vs-pending-store hazard detection is built when WBUF_HAZARD_EN is defined.
module mem_store_wbuf #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [31:0]       st_addr,
  input  logic [31:0]       st_data,
  input  logic [1:0]        st_size,
  output logic              misalign_err,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic [3:0]        ram_be,
  output logic              wbuf_empty,
  input  logic              ld_valid,
  input  logic [31:0]       ld_addr,
  output logic              ld_hazard
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  function automatic logic [31:0] steer_data(input logic [31:0] d, input logic [1:0] sz);
    case (sz)
      2'b00:   steer_data = {4{d[7:0]}};
      2'b01:   steer_data = {2{d[15:0]}};
      default: steer_data = d;
    endcase
  endfunction

  function automatic logic [3:0] steer_be(input logic [1:0] a, input logic [1:0] sz);
    case (sz)
      2'b00:   steer_be = 4'b0001 << a;
      2'b01:   steer_be = a[1] ? 4'b1100 : 4'b0011;
      2'b10:   steer_be = 4'b1111;
      default: steer_be = 4'b0000;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] a, input logic [1:0] sz);
    case (sz)
      2'b00:   is_misaligned = 1'b0;
      2'b01:   is_misaligned = a[0];
      2'b10:   is_misaligned = (a != 2'b00);
      default: is_misaligned = 1'b1;
    endcase
  endfunction

  logic [ADDR_W-1:0] fifo_addr_r [DEPTH];
  logic [31:0]       fifo_data_r [DEPTH];
  logic [3:0]        fifo_be_r   [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
  logic [PTR_W:0]    count_r;
  logic              ram_we_r, misalign_err_r;
  logic [ADDR_W-1:0] ram_addr_r;
  logic [31:0]       ram_wdata_r;
  logic [3:0]        ram_be_r;
  logic              accept_s, bad_s, push_s, pop_s;

  // Full blocks acceptance even on a draining edge, so no same-edge refill.
  assign st_ready = (count_r != FULL_CNT);
  assign accept_s = st_valid && st_ready;
  assign bad_s    = is_misaligned(st_addr[1:0], st_size);
  assign push_s   = accept_s && !bad_s;
  assign pop_s    = (count_r != {(PTR_W+1){1'b0}});

  // FIFO storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        fifo_addr_r[i] <= {ADDR_W{1'b0}};
        fifo_data_r[i] <= 32'h0000_0000;
        fifo_be_r[i]   <= 4'b0000;
      end
    end else begin
      if (push_s) begin
        fifo_addr_r[wr_ptr_r] <= st_addr[ADDR_W+1:2];
        fifo_data_r[wr_ptr_r] <= steer_data(st_data, st_size);
        fifo_be_r[wr_ptr_r]   <= steer_be(st_addr[1:0], st_size);
        wr_ptr_r              <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // RAM write port registers and misalignment pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_we_r       <= 1'b0;
      ram_addr_r     <= {ADDR_W{1'b0}};
      ram_wdata_r    <= 32'h0000_0000;
      ram_be_r       <= 4'b0000;
      misalign_err_r <= 1'b0;
    end else begin
      ram_we_r       <= pop_s;
      misalign_err_r <= accept_s && bad_s;
      if (pop_s) begin
        ram_addr_r  <= fifo_addr_r[rd_ptr_r];
        ram_wdata_r <= fifo_data_r[rd_ptr_r];
        ram_be_r    <= fifo_be_r[rd_ptr_r];
      end
    end
  end

  assign ram_we       = ram_we_r;
  assign ram_addr     = ram_addr_r;
  assign ram_wdata    = ram_wdata_r;
  assign ram_be       = ram_be_r;
  assign misalign_err = misalign_err_r;
  assign wbuf_empty   = (count_r == {(PTR_W+1){1'b0}}) && !ram_we_r;

`ifdef WBUF_HAZARD_EN
  logic              hit_s;
  logic [PTR_W-1:0]  off_s;
  logic [ADDR_W-1:0] ld_word_s;
  logic              unused_s;

  assign ld_word_s = ld_addr[ADDR_W+1:2];
  assign unused_s  = ^{st_addr[31:ADDR_W+2], ld_addr[31:ADDR_W+2], ld_addr[1:0]};

  // An entry is live when its distance from the read pointer is below the count.
  always_comb begin
    hit_s = 1'b0;
    off_s = {PTR_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      off_s = PTR_W'(i) - rd_ptr_r;
      if (({1'b0, off_s} < count_r) && (fifo_addr_r[i] == ld_word_s)) begin
        hit_s = 1'b1;
      end else begin
        hit_s = hit_s;
      end
    end
  end

  assign ld_hazard = ld_valid && (hit_s || (ram_we_r && (ram_addr_r == ld_word_s)));
`else
  logic unused_s;
  assign unused_s  = ^{st_addr[31:ADDR_W+2], ld_valid, ld_addr};
  assign ld_hazard = 1'b0;
`endif

endmodule

// File: tb/tb_mem_store_wbuf.sv
// Randomized bench for mem_store_wbuf: a queue-based model predicts every RAM write and status output.
module tb_mem_store_wbuf;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 10;
`ifdef WBUF_HAZARD_EN
  localparam logic HZ = 1'b1;
`else
  localparam logic HZ = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              st_valid = 1'b0;
  logic              st_ready;
  logic [31:0]       st_addr = 32'h0;
  logic [31:0]       st_data = 32'h0;
  logic [1:0]        st_size = 2'b00;
  logic              misalign_err;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [3:0]        ram_be;
  logic              wbuf_empty;
  logic              ld_valid = 1'b0;
  logic [31:0]       ld_addr = 32'h0;
  logic              ld_hazard;

  mem_store_wbuf #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
    .misalign_err(misalign_err), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_be(ram_be), .wbuf_empty(wbuf_empty),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hazard(ld_hazard)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
    logic [3:0]        be;
  } ent_t;

  ent_t              q[$];
  logic              m_we = 1'b0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [31:0]       m_wdata = 32'h0;
  logic [3:0]        m_be = 4'h0;
  logic              m_mis = 1'b0;
  int                total = 0;
  int                bad = 0;
  logic              checking = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain queue of pending writes, stepped at each edge.
  initial begin : model
    ent_t e;
    int   a;
    logic acc, mis;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        q.delete();
        m_we = 1'b0; m_addr = '0; m_wdata = 32'h0; m_be = 4'h0; m_mis = 1'b0;
      end else begin
        acc = st_valid && (q.size() != DEPTH);
        if (q.size() > 0) begin
          e = q.pop_front();
          m_we = 1'b1; m_addr = e.a; m_wdata = e.d; m_be = e.be;
        end else begin
          m_we = 1'b0;
        end
        m_mis = 1'b0;
        if (acc) begin
          a   = int'(st_addr[1:0]);
          mis = (st_size == 2'd3) || (st_size == 2'd1 && (a % 2) == 1) ||
                (st_size == 2'd2 && a != 0);
          if (mis) begin
            m_mis = 1'b1;
          end else begin
            e.a = st_addr[ADDR_W+1:2];
            case (st_size)
              2'd0: begin e.d = 32'(st_data[7:0]) * 32'h0101_0101; e.be = 4'(1 << a); end
              2'd1: begin e.d = 32'(st_data[15:0]) * 32'h0001_0001; e.be = (a >= 2) ? 4'hC : 4'h3; end
              default: begin e.d = st_data; e.be = 4'hF; end
            endcase
            q.push_back(e);
          end
        end
      end
    end
  end

  function automatic logic exp_hazard();
    logic h = 1'b0;
    if (HZ && ld_valid) begin
      foreach (q[i]) if (q[i].a == ld_addr[ADDR_W+1:2]) h = 1'b1;
      if (m_we && m_addr == ld_addr[ADDR_W+1:2]) h = 1'b1;
    end
    return h;
  endfunction

  // Compare process: every output against the model, mid-cycle.
  initial begin : compare
    forever begin
      @(negedge clk);
      if (checking) begin
        chk("ram_we", 32'(ram_we), 32'(m_we));
        chk("ram_addr", 32'(ram_addr), 32'(m_addr));
        chk("ram_wdata", ram_wdata, m_wdata);
        chk("ram_be", 32'(ram_be), 32'(m_be));
        chk("misalign_err", 32'(misalign_err), 32'(m_mis));
        chk("st_ready", 32'(st_ready), 32'(q.size() != DEPTH));
        chk("wbuf_empty", 32'(wbuf_empty), 32'(q.size() == 0 && !m_we));
        chk("ld_hazard", 32'(ld_hazard), 32'(exp_hazard()));
      end
    end
  end

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    st_valid = 1'b1; st_addr = a; st_data = d; st_size = s;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    int n;
    #1 rst = 1'b0;
    #1 checking = 1'b1;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    chk("reset_we", 32'(ram_we), 32'd0);
    chk("reset_ready", 32'(st_ready), 32'd1);
    chk("reset_empty", 32'(wbuf_empty), 32'd1);

    // SW aligned word
    drive(32'h0000_0010, 32'hDEAD_BEEF, 2'b10); tick(); st_valid = 1'b0; tick();
    chk("t2_we", 32'(ram_we), 32'd1);
    chk("t2_addr", 32'(ram_addr), 32'd4);
    chk("t2_wdata", ram_wdata, 32'hDEAD_BEEF);
    chk("t2_be", 32'(ram_be), 32'hF);

    // SB then SH, back to back
    drive(32'h0000_0013, 32'h0000_005A, 2'b00); tick();
    drive(32'h0000_0016, 32'h0000_1234, 2'b01); tick(); st_valid = 1'b0;
    chk("t3a_addr", 32'(ram_addr), 32'd4);
    chk("t3a_wdata", ram_wdata, 32'h5A5A_5A5A);
    chk("t3a_be", 32'(ram_be), 32'h8);
    tick();
    chk("t3b_addr", 32'(ram_addr), 32'd5);
    chk("t3b_wdata", ram_wdata, 32'h1234_1234);
    chk("t3b_be", 32'(ram_be), 32'hC);
    tick();

    // Misaligned half and word are dropped, aligned word follows
    drive(32'h0000_0011, 32'h0000_1111, 2'b01); tick();
    chk("t4a_mis", 32'(misalign_err), 32'd1);
    chk("t4a_we", 32'(ram_we), 32'd0);
    drive(32'h0000_0022, 32'h2222_2222, 2'b10); tick();
    chk("t4b_mis", 32'(misalign_err), 32'd1);
    chk("t4b_we", 32'(ram_we), 32'd0);
    drive(32'h0000_0020, 32'hCAFE_F00D, 2'b10); tick(); st_valid = 1'b0;
    chk("t4c_mis", 32'(misalign_err), 32'd0);
    tick();
    chk("t4c_we", 32'(ram_we), 32'd1);
    chk("t4c_addr", 32'(ram_addr), 32'd8);
    chk("t4c_wdata", ram_wdata, 32'hCAFE_F00D);

    // Six back-to-back words, then bounded wait for empty
    for (int i = 0; i < 6; i++) begin
      drive(32'h0000_0100 + 32'(4 * i), 32'h1000_0000 + 32'(i), 2'b10); tick();
    end
    st_valid = 1'b0;
    n = 0;
    while (!wbuf_empty && n < 10) begin tick(); n++; end
    chk("t5_empty", 32'(wbuf_empty), 32'd1);

    // Load hazard against a pending and then in-flight store
    drive(32'h0000_0040, 32'h4444_4444, 2'b10); ld_valid = 1'b1; ld_addr = 32'h0000_0042;
    tick(); st_valid = 1'b0;
    chk("t6_haz_q", 32'(ld_hazard), 32'(HZ));
    tick();
    chk("t6_haz_we", 32'(ld_hazard), 32'(HZ));
    tick();
    chk("t6_haz_done", 32'(ld_hazard), 32'd0);
    drive(32'h0000_0040, 32'h4545_4545, 2'b10); ld_addr = 32'h0000_0044; tick(); st_valid = 1'b0;
    chk("t6_haz_other", 32'(ld_hazard), 32'd0);
    ld_valid = 1'b0; tick();

    // Reset in the middle of a stream
    drive(32'h0000_0200, 32'hA0A0_A0A0, 2'b10); tick();
    drive(32'h0000_0204, 32'hB0B0_B0B0, 2'b10); tick();
    drive(32'h0000_0208, 32'hC0C0_C0C0, 2'b10);
    rst = 1'b0; #1;
    chk("t1_we", 32'(ram_we), 32'd0);
    chk("t1_empty", 32'(wbuf_empty), 32'd1);
    st_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick(); tick();
    chk("t1_nostale", 32'(ram_we), 32'd0);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      st_valid = ($urandom_range(0, 3) != 0);
      st_addr  = ($urandom() & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
      st_data  = $urandom();
      st_size  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      ld_valid = $urandom_range(0, 1) == 1;
      ld_addr  = ($urandom() & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
      if (i == 250) rst = 1'b0;
      if (i == 252) rst = 1'b1;
      tick();
    end
    st_valid = 1'b0; ld_valid = 1'b0;
    repeat (10) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
